// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared state encoding and default widths for the memory stage
package mem_stage_pkg;

   localparam int DEF_DATA_W = 24;
   localparam int DEF_ADDR_W = 16;
   localparam int DEF_REG_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } memState_t;

endpackage

// File: rtl/memory_stage_if.sv
// rtl/memory_stage_if.sv - data-memory req/ack bus between the memory stage and data memory
interface memory_stage_if #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 16
);
   logic              memReq;
   logic              memWe;
   logic [ADDR_W-1:0] memAddr;
   logic [DATA_W-1:0] memWdata;
   logic              memAck;
   logic [DATA_W-1:0] memRdata;

   modport master (
      output memReq, memWe, memAddr, memWdata,
      input  memAck, memRdata
   );

   modport slave (
      input  memReq, memWe, memAddr, memWdata,
      output memAck, memRdata
   );
endinterface

// File: rtl/mem_access_fsm.sv
// rtl/mem_access_fsm.sv - access sequencer: state, request registers, load buffer and stall
module mem_access_fsm
   import mem_stage_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                memOp,
   input  logic                memWeIn,
   input  logic [ADDR_W-1:0]   memAddrIn,
   input  logic [DATA_W-1:0]   dataToWriteIn,
   memory_stage_if.master      mem,
   output memState_t           state,
   output logic [DATA_W-1:0]   loadBuf,
   output logic                stall
);

   memState_t next_state;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      stall      = 1'b0;
      case (state)
         IDLE: begin
            if (memOp) begin
               stall      = 1'b1;
               next_state = REQ;
            end
         end
         REQ: begin
            stall = 1'b1;
            if (mem.memAck) next_state = DONE;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Request fields stay frozen for the whole REQ phase; memWe drops with memReq.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem.memReq   <= 1'b0;
         mem.memWe    <= 1'b0;
         mem.memAddr  <= '0;
         mem.memWdata <= '0;
         loadBuf      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (memOp) begin
                  mem.memReq   <= 1'b1;
                  mem.memWe    <= memWeIn;
                  mem.memAddr  <= memAddrIn;
                  mem.memWdata <= dataToWriteIn;
               end
            end
            REQ: begin
               if (mem.memAck) begin
                  mem.memReq <= 1'b0;
                  mem.memWe  <= 1'b0;
                  loadBuf    <= mem.memRdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - memory pipeline stage with MEM/WB register; MEM_FWD_EN enables ALU forwarding
module memory_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int REG_W  = DEF_REG_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memWeIn,
   input  logic              regWeIn,
   input  logic              writeRegFromAluIn,
   input  logic [REG_W-1:0]  regToWriteIn,
   input  logic [DATA_W-1:0] dataToWriteIn,
   input  logic [DATA_W-1:0] resultIn,
   output logic              stall,
   memory_stage_if.master    mem,
   output logic              regWeOut,
   output logic [REG_W-1:0]  regToWriteOut,
   output logic [DATA_W-1:0] writeDataOut,
   output logic              fwdValid,
   output logic [REG_W-1:0]  fwdReg,
   output logic [DATA_W-1:0] fwdData
);

   memState_t         state;
   logic [DATA_W-1:0] loadBuf;
   logic              memOp;

   assign memOp = memWeIn | (regWeIn & ~writeRegFromAluIn);

   mem_access_fsm #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_fsm (
      .clk           (clk),
      .reset         (reset),
      .memOp         (memOp),
      .memWeIn       (memWeIn),
      .memAddrIn     (resultIn[ADDR_W-1:0]),
      .dataToWriteIn (dataToWriteIn),
      .mem           (mem),
      .state         (state),
      .loadBuf       (loadBuf),
      .stall         (stall)
   );

   // Upstream holds its inputs while stalled, so DONE still sees the access instruction.
   always_ff @(posedge clk) begin
      if (reset) begin
         regWeOut      <= 1'b0;
         regToWriteOut <= '0;
         writeDataOut  <= '0;
      end else if (state == IDLE && !memOp) begin
         regWeOut      <= regWeIn;
         regToWriteOut <= regToWriteIn;
         writeDataOut  <= resultIn;
      end else if (state == DONE) begin
         regWeOut      <= regWeIn;
         regToWriteOut <= regToWriteIn;
         writeDataOut  <= writeRegFromAluIn ? resultIn : loadBuf;
      end else begin
         regWeOut      <= 1'b0;
         regToWriteOut <= '0;
         writeDataOut  <= '0;
      end
   end

`ifdef MEM_FWD_EN
   assign fwdValid = regWeIn & writeRegFromAluIn & (state == IDLE);
   assign fwdReg   = regToWriteIn;
   assign fwdData  = resultIn;
`else
   assign fwdValid = 1'b0;
   assign fwdReg   = '0;
   assign fwdData  = '0;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - randomized self-checking bench with an instruction-level reference model
module tb_memory_stage;

   localparam int DATA_W = 24;
   localparam int ADDR_W = 16;
   localparam int REG_W  = 4;
`ifdef MEM_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              memWeIn, regWeIn, writeRegFromAluIn;
   logic [REG_W-1:0]  regToWriteIn;
   logic [DATA_W-1:0] dataToWriteIn, resultIn;
   logic              stall, regWeOut, fwdValid;
   logic [REG_W-1:0]  regToWriteOut, fwdReg;
   logic [DATA_W-1:0] writeDataOut, fwdData;

   int tests = 0;
   int fails = 0;

   memory_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_if ();

   memory_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
      .clk               (clk),
      .reset             (reset),
      .memWeIn           (memWeIn),
      .regWeIn           (regWeIn),
      .writeRegFromAluIn (writeRegFromAluIn),
      .regToWriteIn      (regToWriteIn),
      .dataToWriteIn     (dataToWriteIn),
      .resultIn          (resultIn),
      .stall             (stall),
      .mem               (mem_if),
      .regWeOut          (regWeOut),
      .regToWriteOut     (regToWriteOut),
      .writeDataOut      (writeDataOut),
      .fwdValid          (fwdValid),
      .fwdReg            (fwdReg),
      .fwdData           (fwdData)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_inputs(input bit mwe, input bit rwe, input bit alu, input logic [REG_W-1:0] rd,
                             input logic [DATA_W-1:0] wdat, input logic [DATA_W-1:0] res);
      memWeIn           = mwe;
      regWeIn           = rwe;
      writeRegFromAluIn = alu;
      regToWriteIn      = rd;
      dataToWriteIn     = wdat;
      resultIn          = res;
   endtask

   // Entered just after a clock edge; returns just after the edge that retires the instruction.
   // The memory model acks in the k-th cycle memReq is seen high and fires spurious acks otherwise.
   task automatic run_instr(input bit mwe, input bit rwe, input bit alu, input logic [REG_W-1:0] rd,
                            input logic [DATA_W-1:0] wdat, input logic [DATA_W-1:0] res,
                            input int k, input logic [DATA_W-1:0] rdat);
      bit mem_op;
      int cyc, stalls, reqs;
      bit done;
      mem_op = mwe | (rwe & ~alu);
      cyc = 0; stalls = 0; reqs = 0; done = 1'b0;
      set_inputs(mwe, rwe, alu, rd, wdat, res);
      while (!done) begin
         @(negedge clk);
         if (cyc == 0) begin
            check("fwd_valid", {31'b0, fwdValid}, {31'b0, FWD & rwe & alu});
            check("fwd_reg", {28'b0, fwdReg}, FWD ? {28'b0, rd} : 32'b0);
            check("fwd_data", {8'b0, fwdData}, FWD ? {8'b0, res} : 32'b0);
         end else begin
            check("fwd_valid_busy", {31'b0, fwdValid}, 32'b0);
            check("bubble_we", {31'b0, regWeOut}, 32'b0);
         end
         if (mem_if.memReq) begin
            reqs++;
            check("mem_addr", {16'b0, mem_if.memAddr}, {16'b0, res[ADDR_W-1:0]});
            check("mem_wdata", {8'b0, mem_if.memWdata}, {8'b0, wdat});
            check("mem_we", {31'b0, mem_if.memWe}, {31'b0, mwe});
            mem_if.memAck   = (reqs == k);
            mem_if.memRdata = (reqs == k) ? rdat : DATA_W'($urandom);
         end else begin
            mem_if.memAck   = 1'($urandom_range(0, 1));
            mem_if.memRdata = DATA_W'($urandom);
         end
         if (stall) stalls++;
         else       done = 1'b1;
         cyc++;
         @(posedge clk);
         #1;
         mem_if.memAck = 1'b0;
         if (!done && cyc > 40) begin
            check("timeout", 32'(cyc), 32'd0);
            done = 1'b1;
         end
      end
      check("stall_cycles", 32'(stalls), mem_op ? 32'(k + 1) : 32'd0);
      check("req_cycles", 32'(reqs), mem_op ? 32'(k) : 32'd0);
      check("wb_we", {31'b0, regWeOut}, {31'b0, rwe});
      check("wb_reg", {28'b0, regToWriteOut}, {28'b0, rd});
      check("wb_data", {8'b0, writeDataOut}, {8'b0, (!mem_op || alu) ? res : rdat});
   endtask

   initial begin
      reset = 1'b1;
      set_inputs(1'b0, 1'b0, 1'b1, '0, '0, '0);
      mem_if.memAck   = 1'b0;
      mem_if.memRdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_memreq", {31'b0, mem_if.memReq}, 32'd0);
      check("rst_memwe", {31'b0, mem_if.memWe}, 32'd0);
      check("rst_memaddr", {16'b0, mem_if.memAddr}, 32'd0);
      check("rst_memwdata", {8'b0, mem_if.memWdata}, 32'd0);
      check("rst_regwe", {31'b0, regWeOut}, 32'd0);
      check("rst_regto", {28'b0, regToWriteOut}, 32'd0);
      check("rst_wdata", {8'b0, writeDataOut}, 32'd0);
      check("rst_stall", {31'b0, stall}, 32'd0);
      reset = 1'b0;

      run_instr(1'b0, 1'b1, 1'b1, 4'd3, 24'h0, 24'h000123, 1, 24'h0);
      run_instr(1'b0, 1'b1, 1'b0, 4'd7, 24'h0, 24'h000040, 3, 24'hABCDEF);
      run_instr(1'b1, 1'b0, 1'b1, 4'd2, 24'h55AA55, 24'h000010, 1, 24'h0);
      run_instr(1'b0, 1'b1, 1'b1, 4'd5, 24'h0, 24'h000777, 1, 24'h0);
      run_instr(1'b0, 1'b1, 1'b0, 4'd1, 24'h0, 24'h001234, 1, 24'h13579B);
      run_instr(1'b0, 1'b1, 1'b0, 4'd9, 24'h0, 24'hFF4321, 2, 24'h2468AC);

      // Reset in the second REQ cycle, then a stale ack must be ignored.
      set_inputs(1'b0, 1'b1, 1'b0, 4'd6, 24'h0, 24'h000080);
      @(posedge clk); #1;
      check("rr_req_first", {31'b0, mem_if.memReq}, 32'd1);
      @(posedge clk); #1;
      check("rr_req_second", {31'b0, mem_if.memReq}, 32'd1);
      reset = 1'b1;
      set_inputs(1'b0, 1'b0, 1'b1, '0, '0, '0);
      @(posedge clk); #1;
      reset = 1'b0;
      check("rr_memreq", {31'b0, mem_if.memReq}, 32'd0);
      check("rr_stall", {31'b0, stall}, 32'd0);
      check("rr_regwe", {31'b0, regWeOut}, 32'd0);
      check("rr_regto", {28'b0, regToWriteOut}, 32'd0);
      check("rr_wdata", {8'b0, writeDataOut}, 32'd0);
      mem_if.memAck   = 1'b1;
      mem_if.memRdata = 24'hDEAD01;
      @(posedge clk); #1;
      mem_if.memAck = 1'b0;
      check("rr_late_ack_req", {31'b0, mem_if.memReq}, 32'd0);
      check("rr_late_ack_stall", {31'b0, stall}, 32'd0);
      run_instr(1'b0, 1'b1, 1'b1, 4'd4, 24'h0, 24'h00ABCD, 1, 24'h0);

      for (int i = 0; i < 200; i++) begin
         int kind;
         bit mwe, rwe, alu;
         kind = $urandom_range(0, 4);
         case (kind)
            0:       begin mwe = 1'b0; rwe = 1'b1; alu = 1'b1; end
            1:       begin mwe = 1'b0; rwe = 1'b1; alu = 1'b0; end
            2:       begin mwe = 1'b1; rwe = 1'b0; alu = 1'($urandom_range(0, 1)); end
            3:       begin mwe = 1'b0; rwe = 1'b0; alu = 1'($urandom_range(0, 1)); end
            default: begin mwe = 1'b1; rwe = 1'b1; alu = 1'b1; end
         endcase
         run_instr(mwe, rwe, alu, REG_W'($urandom), DATA_W'($urandom), DATA_W'($urandom),
                   $urandom_range(1, 4), DATA_W'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
